// File: rtl/flot_sqrt_rr_scheduler.sv
// Round-robin scheduler sharing one pipelined float sqrt unit among NREQ requesters.
// Latency: transfer at cycle t -> sq_ce at t+1 -> rsp_valid at t+2+LATENCY; one issue per cycle.
// Backpressure: one-hot req_ready grant in RUN only; responses are strobes and cannot be stalled.
// Optional feature macro FLOT_SQRT_NEGCHK_EN: negative/Inf/NaN operands are answered with a quiet NaN.
module flot_sqrt_rr_scheduler #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int LATENCY = 3
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_op,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_result,
  output logic                  rsp_exce,
  input  logic                  flush,
  output logic                  flush_done,
  output logic                  busy,
  output logic                  sq_ce,
  output logic [WIDTH-1:0]      sq_op,
  output logic                  sq_exce_in,
  input  logic [WIDTH-1:0]      sq_result,
  input  logic                  sq_exce_out
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            cand;
  logic [IW-1:0]            grant_idx;
  logic                     grant_any;
  logic                     xfer;
  logic [WIDTH-1:0]         sel_op;
  // Stage k holds the issue that entered the sqrt unit k cycles ago; stage LATENCY lines up
  // with the unit's output.
  logic [LATENCY:0]         tag_vld;
  logic [LATENCY:0][IW-1:0] tag_idx;

`ifdef FLOT_SQRT_NEGCHK_EN
  localparam int EW = (WIDTH == 64) ? 11 : (WIDTH == 16) ? 5 : 8;
  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EW{1'b1}}, 1'b1, {(WIDTH-EW-2){1'b0}}};
  logic [LATENCY:0] tag_bad;
  logic             sel_bad;

  // Negative nonzero operands and Inf/NaN inputs have no real root.
  assign sel_bad    = (sel_op[WIDTH-1] && (|sel_op[WIDTH-2:0])) || (&sel_op[WIDTH-2 -: EW]);
  // Stage 0 of the bad-flag pipe is aligned with sq_op, so it doubles as the unit's exception input.
  assign sq_exce_in = tag_bad[0];

  // Carry the bad-operand flag alongside the tag so the response can be overridden.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tag_bad <= '0;
    end else begin
      tag_bad <= {tag_bad[LATENCY-1:0], (xfer & sel_bad)};
    end
  end
`else
  assign sq_exce_in = 1'b0;
`endif

  // Round-robin search: first valid requester after the last one granted, with wrap-around.
  always_comb begin
    grant_idx = rr_ptr;
    grant_any = 1'b0;
    cand      = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IW'(i)) begin
        sel_op = req_op[i*WIDTH +: WIDTH];
      end
    end
  end

  // Grants only exist in RUN and outside reset; the grant only ever targets a valid requester.
  assign xfer       = (state == RUN) && nRST && grant_any;
  assign req_ready  = xfer ? (NREQ'(1) << grant_idx) : '0;
  assign flush_done = (state == FLUSH);
  assign busy       = (|tag_vld) | sq_ce;

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Flush sequencing: stop granting, wait for every tag to retire, hold until flush drops.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush)     state_nxt = DRAIN;
      DRAIN:   if (!(|tag_vld)) state_nxt = FLUSH;
      FLUSH:   if (!flush)    state_nxt = RUN;
      default:                state_nxt = RUN;
    endcase
  end

  // Issue register toward the sqrt unit and round-robin pointer update.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sq_ce  <= 1'b0;
      sq_op  <= '0;
      rr_ptr <= IW'(NREQ - 1);
    end else begin
      sq_ce <= xfer;
      if (xfer) begin
        sq_op  <= sel_op;
        rr_ptr <= grant_idx;
      end
    end
  end

  // Tag pipe advances every cycle regardless of issue.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      tag_vld <= '0;
      tag_idx <= '0;
    end else begin
      tag_vld <= {tag_vld[LATENCY-1:0], xfer};
      tag_idx <= {tag_idx[LATENCY-1:0], grant_idx};
    end
  end

  // Capture the unit output for the tag that lines up with it and strobe its requester.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_exce   <= 1'b0;
    end else if (tag_vld[LATENCY]) begin
      rsp_valid  <= NREQ'(1) << tag_idx[LATENCY];
`ifdef FLOT_SQRT_NEGCHK_EN
      rsp_result <= tag_bad[LATENCY] ? QNAN : sq_result;
      rsp_exce   <= tag_bad[LATENCY] | sq_exce_out;
`else
      rsp_result <= sq_result;
      rsp_exce   <= sq_exce_out;
`endif
    end else begin
      rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_flot_sqrt_rr_scheduler.sv
// Bench for flot_sqrt_rr_scheduler: emulated sqrt unit, directed scenarios with literal
// expectations, then randomized traffic checked every cycle against an issue-history model.
module tb_flot_sqrt_rr_scheduler;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int LAT   = 3;
`ifdef FLOT_SQRT_NEGCHK_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif

  logic                  CLK = 1'b0;
  logic                  nRST = 1'b0;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_op;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_result;
  logic                  rsp_exce;
  logic                  flush;
  logic                  flush_done;
  logic                  busy;
  logic                  sq_ce;
  logic [WIDTH-1:0]      sq_op;
  logic                  sq_exce_in;
  logic [WIDTH-1:0]      sq_result;
  logic                  sq_exce_out;

  int n_tests = 0;
  int n_fail  = 0;

  flot_sqrt_rr_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .LATENCY(LAT)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_op(req_op), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_exce(rsp_exce),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .sq_ce(sq_ce), .sq_op(sq_op), .sq_exce_in(sq_exce_in),
    .sq_result(sq_result), .sq_exce_out(sq_exce_out)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference functions ----------------
  // Emulated unit: exact root for positive powers of four, an arbitrary fixed scramble otherwise.
  function automatic logic [31:0] unit_fn(input logic [31:0] op);
    int e;
    e = int'(op[30:23]) - 127;
    if (!op[31] && op[22:0] == 23'd0 && op[30:23] != 8'h00 && op[30:23] != 8'hFF && (e % 2 == 0))
      return {1'b0, 8'(127 + e / 2), 23'd0};
    return {1'b0, op[31:1]} ^ 32'h1234_5678;
  endfunction

  function automatic logic unit_ex(input logic [31:0] op, input logic exin);
    return exin | (op[31] & (|op[30:0]));
  endfunction

  function automatic logic is_bad(input logic [31:0] op);
    return (op[31] && (|op[30:0])) || (op[30:23] == 8'hFF);
  endfunction

  function automatic logic [31:0] ref_res(input logic [31:0] op);
    return (NEG && is_bad(op)) ? 32'h7FC0_0000 : unit_fn(op);
  endfunction

  function automatic logic ref_exce(input logic [31:0] op);
    return (NEG && is_bad(op)) ? 1'b1 : unit_ex(op, 1'b0);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- emulated sqrt unit (LAT-deep) ----------------
  logic [31:0] u_res [LAT];
  logic        u_ex  [LAT];

  always @(posedge CLK) begin
    u_res[0] <= unit_fn(sq_op);
    u_ex[0]  <= unit_ex(sq_op, sq_exce_in);
    for (int k = 1; k < LAT; k++) begin
      u_res[k] <= u_res[k-1];
      u_ex[k]  <= u_ex[k-1];
    end
  end

  assign sq_result   = u_res[LAT-1];
  assign sq_exce_out = u_ex[LAT-1];

  // ---------------- behavioural model: history of transfers ----------------
  typedef struct {
    int          cyc;
    int          idx;
    logic [31:0] op;
  } rec_t;
  typedef enum {M_RUN, M_DRAIN, M_FLUSH} mode_t;

  rec_t            hist[$];
  rec_t            r;
  mode_t           mode = M_RUN;
  int              cyc = 0;
  int              last_g = NREQ - 1;
  int              g;
  int              age;
  logic [31:0]     last_op = '0;
  logic [NREQ-1:0] one = 1;
  logic [NREQ-1:0] e_ready, e_rsp;
  logic            e_ce, e_busy, e_exin, e_exce;
  logic [31:0]     e_res;

  // Per-cycle compare: every output is derived from which transfers happened how long ago.
  always @(negedge CLK) begin
    #2;
    if (!nRST) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_rsp_exce", rsp_exce, 0);
      check("rst_flush_done", flush_done, 0);
      check("rst_busy", busy, 0);
      check("rst_sq_ce", sq_ce, 0);
      check("rst_sq_op", sq_op, 0);
      check("rst_sq_exce_in", sq_exce_in, 0);
      hist.delete();
      mode    = M_RUN;
      last_g  = NREQ - 1;
      last_op = '0;
    end else begin
      while (hist.size() > 0 && cyc - hist[0].cyc > LAT + 2) void'(hist.pop_front());
      g = -1;
      if (mode == M_RUN) begin
        for (int k = 1; k <= NREQ; k++) begin
          if (g < 0 && req_valid[(last_g + k) % NREQ]) g = (last_g + k) % NREQ;
        end
      end
      e_ready = (g >= 0) ? (one << g) : '0;
      e_ce = 1'b0; e_busy = 1'b0; e_exin = 1'b0; e_rsp = '0; e_res = '0; e_exce = 1'b0;
      foreach (hist[j]) begin
        age = cyc - hist[j].cyc;
        if (age == 1) begin
          e_ce   = 1'b1;
          e_exin = NEG && is_bad(hist[j].op);
        end
        if (age >= 1 && age <= LAT + 1) e_busy = 1'b1;
        if (age == LAT + 2) begin
          e_rsp  = one << hist[j].idx;
          e_res  = ref_res(hist[j].op);
          e_exce = ref_exce(hist[j].op);
        end
      end
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_rsp);
      check("sq_ce", sq_ce, e_ce);
      check("sq_op", sq_op, last_op);
      check("sq_exce_in", sq_exce_in, e_exin);
      check("busy", busy, e_busy);
      check("flush_done", flush_done, (mode == M_FLUSH));
      if (e_rsp != '0) begin
        check("rsp_result", rsp_result, e_res);
        check("rsp_exce", rsp_exce, e_exce);
      end
      if (g >= 0) begin
        r.cyc = cyc; r.idx = g; r.op = req_op[g*WIDTH +: WIDTH];
        hist.push_back(r);
        last_g  = g;
        last_op = r.op;
      end
      case (mode)
        M_RUN:   if (flush)   mode = M_DRAIN;
        M_DRAIN: if (!e_busy) mode = M_FLUSH;
        M_FLUSH: if (!flush)  mode = M_RUN;
        default: mode = M_RUN;
      endcase
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ*WIDTH-1:0] ops, input logic fl);
    @(negedge CLK);
    #1;
    req_valid = v;
    req_op    = ops;
    flush     = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, '0, 1'b0);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    #1;
    nRST = 1'b0; req_valid = '0; flush = 1'b0;
    settle();
    check("t5_rst_rsp", rsp_valid, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ce", sq_ce, 0);
    @(negedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  function automatic logic [31:0] rand_op();
    if ($urandom_range(0, 1) == 1)
      return {1'b0, 8'(127 + 2 * (int'($urandom_range(0, 60)) - 30)), 23'd0};
    return $urandom();
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] rand_ops();
    logic [NREQ*WIDTH-1:0] v;
    for (int i = 0; i < NREQ; i++) v[i*WIDTH +: WIDTH] = rand_op();
    return v;
  endfunction

  logic [31:0]           t3_op [5] = '{32'h3F80_0000, 32'h4080_0000, 32'h4180_0000, 32'h4280_0000, 32'h4380_0000};
  logic [31:0]           t3_rt [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4080_0000, 32'h4100_0000, 32'h4180_0000};
  logic [NREQ-1:0]       t2_g  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [NREQ*WIDTH-1:0] ops;
  logic                  fl;

  initial begin
    req_valid = '0; req_op = '0; flush = 1'b0;
    idle(1);
    @(negedge CLK);
    #1;
    nRST = 1'b1;
    idle(2);

    // 1: single 4.0 from requester 0; root arrives LAT+2 cycles after the transfer.
    ops = '0; ops[31:0] = 32'h4080_0000;
    drive(4'b0001, ops, 1'b0); settle();
    check("t1_ready", req_ready, 4'b0001);
    idle(4); settle();
    check("t1_early", rsp_valid, 4'b0000);
    idle(1); settle();
    check("t1_rsp", rsp_valid, 4'b0001);
    check("t1_result", rsp_result, 32'h4000_0000);
    check("t1_exce", rsp_exce, 1'b0);
    idle(2);

    // 2: all valid; pointer was left at 0 by test 1, so rotation starts at requester 1.
    for (int i = 0; i < 8; i++) begin
      drive(4'hF, rand_ops(), 1'b0); settle();
      if (i < 4) check("t2_rotation", req_ready, t2_g[i]);
    end
    idle(8);

    // 3: requester 2 alone, back-to-back.
    for (int i = 0; i < 5; i++) begin
      ops = '0; ops[2*WIDTH +: WIDTH] = t3_op[i];
      drive(4'b0100, ops, 1'b0); settle();
      check("t3_ready", req_ready, 4'b0100);
    end
    for (int i = 0; i < 5; i++) begin
      idle(1); settle();
      check("t3_rsp", rsp_valid, 4'b0100);
      check("t3_root", rsp_result, t3_rt[i]);
    end
    idle(4);

    // 4: flush after grants 3,0,1; the grant in the cycle flush rises (requester 2) still lands.
    repeat (3) drive(4'hF, rand_ops(), 1'b0);
    drive(4'hF, rand_ops(), 1'b1); settle();
    check("t4_grant_on_flush", req_ready, 4'b0100);
    drive(4'hF, rand_ops(), 1'b1); settle();
    check("t4_blocked", req_ready, 4'b0000);
    repeat (3) drive(4'hF, rand_ops(), 1'b1);
    drive(4'hF, rand_ops(), 1'b1); settle();
    check("t4_last_rsp", rsp_valid, 4'b0100);
    check("t4_not_done", flush_done, 1'b0);
    drive(4'hF, rand_ops(), 1'b1); settle();
    check("t4_done", flush_done, 1'b1);
    check("t4_idle", busy, 1'b0);
    drive(4'hF, rand_ops(), 1'b0); settle();
    check("t4_still_flush", req_ready, 4'b0000);
    drive(4'hF, rand_ops(), 1'b0); settle();
    check("t4_resume", req_ready, 4'b1000);
    idle(8);

    // 5: reset with two in flight; nothing may come back, and the pointer restarts.
    repeat (2) drive(4'b0011, rand_ops(), 1'b0);
    pulse_reset();
    for (int i = 0; i < 7; i++) begin
      idle(1); settle();
      check("t5_no_rsp", rsp_valid, 4'b0000);
    end
    drive(4'hF, rand_ops(), 1'b0); settle();
    check("t5_first_grant", req_ready, 4'b0001);
    idle(8);

    // 6: -4.0 from requester 1.
    ops = '0; ops[WIDTH +: WIDTH] = 32'hC080_0000;
    drive(4'b0010, ops, 1'b0); settle();
    check("t6_ready", req_ready, 4'b0010);
    idle(1); settle();
    check("t6_exce_in", sq_exce_in, NEG);
    idle(3);
    idle(1); settle();
    check("t6_rsp", rsp_valid, 4'b0010);
    check("t6_result", rsp_result, NEG ? 32'h7FC0_0000 : 32'h7274_5678);
    check("t6_exce", rsp_exce, 1'b1);
    idle(4);

    // Randomized traffic with occasional flush episodes and one mid-stream reset.
    fl = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        pulse_reset();
        fl = 1'b0;
      end
      if (!fl) fl = ($urandom_range(0, 99) < 4);
      else     fl = ($urandom_range(0, 99) < 88);
      drive(NREQ'($urandom_range(0, 15)), rand_ops(), fl);
    end
    idle(12);
    settle();
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
